// File: rtl/dmem_pkg.sv
// Shared address map, register bit positions and region decode for data_mem_responder.
// The timer registers decode only when the caller says the timer is built in.
package dmem_pkg;

    localparam logic [31:0] MMIO_BASE = 32'h0000_1000;
    localparam logic [31:0] LED_OFF   = 32'h00;
    localparam logic [31:0] SW_OFF    = 32'h04;
    localparam logic [31:0] TCNT_OFF  = 32'h08;
    localparam logic [31:0] TCMP_OFF  = 32'h0C;
    localparam logic [31:0] TCTRL_OFF = 32'h10;
    localparam logic [31:0] STAT_OFF  = 32'h14;

    localparam logic [31:0] LED_ADDR   = MMIO_BASE + LED_OFF;
    localparam logic [31:0] SW_ADDR    = MMIO_BASE + SW_OFF;
    localparam logic [31:0] TCNT_ADDR  = MMIO_BASE + TCNT_OFF;
    localparam logic [31:0] TCMP_ADDR  = MMIO_BASE + TCMP_OFF;
    localparam logic [31:0] TCTRL_ADDR = MMIO_BASE + TCTRL_OFF;
    localparam logic [31:0] STAT_ADDR  = MMIO_BASE + STAT_OFF;

    localparam int CTRL_EN_BIT    = 0;
    localparam int STAT_MATCH_BIT = 0;

    typedef enum logic [2:0] {
        REG_RAM,
        REG_LED,
        REG_SW,
        REG_TCNT,
        REG_TCMP,
        REG_TCTRL,
        REG_STAT,
        REG_NONE
    } region_e;

    // Misaligned addresses never map, so every caller treats them like holes.
    function automatic region_e decode_region(input logic [31:0] addr,
                                              input logic [31:0] ram_bytes,
                                              input logic        timer_en);
        region_e r;
        r = REG_NONE;
        if (addr[1:0] == 2'b00) begin
            if (addr < ram_bytes)                    r = REG_RAM;
            else if (addr == LED_ADDR)               r = REG_LED;
            else if (addr == SW_ADDR)                r = REG_SW;
            else if (timer_en && addr == TCNT_ADDR)  r = REG_TCNT;
            else if (timer_en && addr == TCMP_ADDR)  r = REG_TCMP;
            else if (timer_en && addr == TCTRL_ADDR) r = REG_TCTRL;
            else if (timer_en && addr == STAT_ADDR)  r = REG_STAT;
        end
        return r;
    endfunction

endpackage

// File: rtl/mmio_timer.sv
// Free-running 32-bit timer with compare register and sticky match flag.
// A match seen in the same cycle as a clear write wins over the clear.
module mmio_timer
    import dmem_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        wr_cnt,
    input  logic        wr_cmp,
    input  logic        wr_ctrl,
    input  logic        wr_stat,
    input  logic [31:0] wdata,
    output logic [31:0] cnt,
    output logic [31:0] cmp,
    output logic        enable,
    output logic        match
);

    logic hit;
    assign hit = enable && (cnt == cmp);

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt    <= '0;
            cmp    <= '0;
            enable <= 1'b0;
            match  <= 1'b0;
        end else begin
            if (wr_cnt)
                cnt <= wdata;
            else if (enable)
                cnt <= cnt + 32'd1;
            if (wr_cmp)
                cmp <= wdata;
            if (wr_ctrl)
                enable <= wdata[CTRL_EN_BIT];
            if (hit)
                match <= 1'b1;
            else if (wr_stat && wdata[STAT_MATCH_BIT])
                match <= 1'b0;
        end
    end

endmodule

// File: rtl/data_mem_responder.sv
// Zero-latency data memory with LED/switch MMIO and a sticky bus-error flag.
// Defining DMEM_TIMER_EN adds the timer registers (TIMER_CNT/CMP/CTRL, STATUS).
module data_mem_responder
    import dmem_pkg::*;
#(
    parameter int RAM_WORDS = 256,
    parameter int SW_W      = 16
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [31:0]     AddressDataMem,
    input  logic [31:0]     WriteDataMem,
    input  logic            WriteEnableMem,
    output logic [31:0]     ReadData,
    input  logic [SW_W-1:0] switches,
    output logic [SW_W-1:0] leds,
    output logic            bus_error
);

    localparam int          IDX_W     = $clog2(RAM_WORDS);
    localparam logic [31:0] RAM_BYTES = 32'(4 * RAM_WORDS);
`ifdef DMEM_TIMER_EN
    localparam bit TIMER_EN = 1'b1;
`else
    localparam bit TIMER_EN = 1'b0;
`endif

    region_e          region;
    logic [IDX_W-1:0] ram_idx;
    logic [31:0]      mem [RAM_WORDS];
    logic [SW_W-1:0]  led_q;
    logic [SW_W-1:0]  sw_meta;
    logic [SW_W-1:0]  sw_sync;
    logic             bus_error_q;

    assign region  = decode_region(AddressDataMem, RAM_BYTES, TIMER_EN);
    assign ram_idx = AddressDataMem[IDX_W+1:2];
    assign leds      = led_q;
    assign bus_error = bus_error_q;

    // RAM keeps its contents across reset; writes under reset are dropped.
    always_ff @(posedge clk) begin
        if (!reset && WriteEnableMem && region == REG_RAM)
            mem[ram_idx] <= WriteDataMem;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            led_q       <= '0;
            sw_meta     <= '0;
            sw_sync     <= '0;
            bus_error_q <= 1'b0;
        end else begin
            sw_meta <= switches;
            sw_sync <= sw_meta;
            if (WriteEnableMem && region == REG_LED)
                led_q <= WriteDataMem[SW_W-1:0];
            if (WriteEnableMem && (region == REG_NONE || region == REG_SW))
                bus_error_q <= 1'b1;
        end
    end

`ifdef DMEM_TIMER_EN
    logic [31:0] t_cnt;
    logic [31:0] t_cmp;
    logic        t_enable;
    logic        t_match;

    mmio_timer u_timer (
        .clk     (clk),
        .reset   (reset),
        .wr_cnt  (WriteEnableMem && region == REG_TCNT),
        .wr_cmp  (WriteEnableMem && region == REG_TCMP),
        .wr_ctrl (WriteEnableMem && region == REG_TCTRL),
        .wr_stat (WriteEnableMem && region == REG_STAT),
        .wdata   (WriteDataMem),
        .cnt     (t_cnt),
        .cmp     (t_cmp),
        .enable  (t_enable),
        .match   (t_match)
    );
`endif

    always_comb begin
        ReadData = '0;
        case (region)
            REG_RAM: ReadData = mem[ram_idx];
            REG_LED: ReadData = 32'(led_q);
            REG_SW:  ReadData = 32'(sw_sync);
`ifdef DMEM_TIMER_EN
            REG_TCNT:  ReadData = t_cnt;
            REG_TCMP:  ReadData = t_cmp;
            REG_TCTRL: ReadData[CTRL_EN_BIT]    = t_enable;
            REG_STAT:  ReadData[STAT_MATCH_BIT] = t_match;
`endif
            default: ReadData = '0;
        endcase
    end

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder: memory-map model plus literal expectations.
// Timer checks are included when DMEM_TIMER_EN is defined, unmapped checks otherwise.
module tb_data_mem_responder;

    localparam int SW_W = 16;

    logic            clk = 1'b0;
    logic            reset;
    logic [31:0]     AddressDataMem;
    logic [31:0]     WriteDataMem;
    logic            WriteEnableMem;
    logic [31:0]     ReadData;
    logic [SW_W-1:0] switches;
    logic [SW_W-1:0] leds;
    logic            bus_error;

    data_mem_responder #(.RAM_WORDS(256), .SW_W(SW_W)) dut (
        .clk            (clk),
        .reset          (reset),
        .AddressDataMem (AddressDataMem),
        .WriteDataMem   (WriteDataMem),
        .WriteEnableMem (WriteEnableMem),
        .ReadData       (ReadData),
        .switches       (switches),
        .leds           (leds),
        .bus_error      (bus_error)
    );

    // clock / reset
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    bit done = 1'b0;
    bit model_valid = 1'b0;

    logic [31:0] exp_q[$];
    string       lit_name = "lit";

    // memory-map model
    logic [31:0]     ram_m [256];
    bit              ram_known [256];
    logic [SW_W-1:0] led_m;
    logic            buserr_m;
    logic [SW_W-1:0] sw_samples[$];
    logic [31:0]     tcnt_m, tcmp_m;
    logic            ten_m, match_m;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [32:0] model_read(input logic [31:0] a);
        logic [32:0] r;
        int n;
        r = {1'b1, 32'h0};
        n = sw_samples.size();
        if (a[1:0] != 2'b00) r = {1'b1, 32'h0};
        else if (a < 32'd1024) r = {ram_known[a[9:2]], ram_m[a[9:2]]};
        else if (a == 32'h1000) r = {1'b1, 16'h0, led_m};
        else if (a == 32'h1004) r = {1'b1, 16'h0, (n >= 2) ? sw_samples[n-2] : 16'h0};
`ifdef DMEM_TIMER_EN
        else if (a == 32'h1008) r = {1'b1, tcnt_m};
        else if (a == 32'h100C) r = {1'b1, tcmp_m};
        else if (a == 32'h1010) r = {1'b1, 31'h0, ten_m};
        else if (a == 32'h1014) r = {1'b1, 31'h0, match_m};
`endif
        return r;
    endfunction

    always @(posedge clk) begin
        logic [31:0] a, d;
        logic        hit, old_en;
        a = AddressDataMem;
        d = WriteDataMem;
        if (reset) begin
            led_m = '0; buserr_m = 1'b0; sw_samples.delete();
            tcnt_m = '0; tcmp_m = '0; ten_m = 1'b0; match_m = 1'b0;
            model_valid = 1'b1;
        end else begin
            sw_samples.push_back(switches);
            old_en = ten_m;
            hit = ten_m && (tcnt_m == tcmp_m);
`ifdef DMEM_TIMER_EN
            if (!(WriteEnableMem && a == 32'h1008) && old_en) tcnt_m = tcnt_m + 1;
`endif
            if (WriteEnableMem) begin
                if (a[1:0] != 2'b00) buserr_m = 1'b1;
                else if (a < 32'd1024) begin ram_m[a[9:2]] = d; ram_known[a[9:2]] = 1'b1; end
                else if (a == 32'h1000) led_m = d[SW_W-1:0];
`ifdef DMEM_TIMER_EN
                else if (a == 32'h1008) tcnt_m = d;
                else if (a == 32'h100C) tcmp_m = d;
                else if (a == 32'h1010) ten_m = d[0];
                else if (a == 32'h1014) begin if (d[0]) match_m = 1'b0; end
`endif
                else buserr_m = 1'b1;
            end
            if (hit) match_m = 1'b1;
        end
    end

    // compare process: every cycle once the model has seen a reset edge
    always @(negedge clk) begin
        logic [32:0] r;
        if (model_valid && !done) begin
            r = model_read(AddressDataMem);
            if (r[32]) check("rdata_model", ReadData, r[31:0]);
            check("leds_model", 32'(leds), 32'(led_m));
            check("buserr_model", 32'(bus_error), 32'(buserr_m));
            if (exp_q.size() > 0) check(lit_name, ReadData, exp_q.pop_front());
        end
    end

    // driver tasks
    task automatic step(input logic [31:0] a, input logic [31:0] d, input logic we);
        AddressDataMem = a;
        WriteDataMem   = d;
        WriteEnableMem = we;
        @(posedge clk);
        #1;
    endtask

    task automatic step_exp(input string name, input logic [31:0] a, input logic [31:0] d,
                            input logic we, input logic [31:0] exp);
        lit_name = name;
        exp_q.push_back(exp);
        step(a, d, we);
    endtask

    task automatic rd_exp(input string name, input logic [31:0] a, input logic [31:0] exp);
        step_exp(name, a, 32'h0, 1'b0, exp);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step(32'h1000, 32'h5555, 1'b1);
        step(32'h10, 32'h7777_7777, 1'b1);
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        AddressDataMem = '0;
        WriteDataMem = '0;
        WriteEnableMem = 1'b0;
        switches = '0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;

        rd_exp("led_rst", 32'h1000, 32'h0);
        rd_exp("sw_rst", 32'h1004, 32'h0);
        check("buserr_rst", 32'(bus_error), 32'h0);
        check("leds_rst", 32'(leds), 32'h0);

        step(32'h10, 32'h1111_1111, 1'b1);
        step_exp("rdw_old", 32'h10, 32'hDEAD_BEEF, 1'b1, 32'h1111_1111);
        rd_exp("ram_new", 32'h10, 32'hDEAD_BEEF);
        step(32'h3FC, 32'h0BAD_F00D, 1'b1);
        rd_exp("ram_last", 32'h3FC, 32'h0BAD_F00D);

        step(32'h1000, 32'h0000_A5A5, 1'b1);
        check("leds_a5a5", 32'(leds), 32'h0000_A5A5);
        rd_exp("led_rd", 32'h1000, 32'h0000_A5A5);
        step(32'h1000, 32'hFFFF_FFFF, 1'b1);
        rd_exp("led_unused_bits", 32'h1000, 32'h0000_FFFF);

        switches = 16'h1234;
        rd_exp("sw_lag0", 32'h1004, 32'h0);
        rd_exp("sw_lag1", 32'h1004, 32'h0);
        rd_exp("sw_lag2", 32'h1004, 32'h1234);

        check("buserr_clean", 32'(bus_error), 32'h0);
        step_exp("unal_rd", 32'h12, 32'hCAFE_F00D, 1'b1, 32'h0);
        check("buserr_unal", 32'(bus_error), 32'h1);
        rd_exp("ram_keep", 32'h10, 32'hDEAD_BEEF);
        rd_exp("unal_led_rd", 32'h1001, 32'h0);
        check("buserr_sticky", 32'(bus_error), 32'h1);

        do_reset();
        check("buserr_cleared", 32'(bus_error), 32'h0);
        check("leds_wr_in_reset", 32'(leds), 32'h0);
        rd_exp("ram_norst", 32'h10, 32'hDEAD_BEEF);
        rd_exp("led_rst2", 32'h1000, 32'h0);

        step(32'h2000, 32'h1, 1'b1);
        check("buserr_unmap", 32'(bus_error), 32'h1);
        rd_exp("unmap_rd", 32'h2000, 32'h0);
        rd_exp("ram_end_rd", 32'h400, 32'h0);

        do_reset();
        step(32'h400, 32'h1, 1'b1);
        check("buserr_ram_end", 32'(bus_error), 32'h1);

        do_reset();
        step(32'h1004, 32'hFFFF, 1'b1);
        check("buserr_sw_wr", 32'(bus_error), 32'h1);

        do_reset();
`ifdef DMEM_TIMER_EN
        step(32'h1008, 32'hFFFF_FFFE, 1'b1);
        step(32'h100C, 32'h0000_0001, 1'b1);
        step(32'h1010, 32'h1, 1'b1);
        rd_exp("cnt_fe", 32'h1008, 32'hFFFF_FFFE);
        rd_exp("cnt_ff", 32'h1008, 32'hFFFF_FFFF);
        rd_exp("cnt_wrap", 32'h1008, 32'h0);
        rd_exp("stat_pre", 32'h1014, 32'h0);
        rd_exp("stat_match", 32'h1014, 32'h1);
        step(32'h1008, 32'h100, 1'b1);
        rd_exp("cnt_wr_prec", 32'h1008, 32'h100);
        rd_exp("cnt_inc", 32'h1008, 32'h101);
        step(32'h1010, 32'h0, 1'b1);
        step(32'h1008, 32'h7, 1'b1);
        step(32'h100C, 32'h7, 1'b1);
        step(32'h1014, 32'h1, 1'b1);
        rd_exp("stat_clr", 32'h1014, 32'h0);
        rd_exp("ctrl_off", 32'h1010, 32'h0);
        step(32'h1010, 32'h1, 1'b1);
        step(32'h1014, 32'h1, 1'b1);
        rd_exp("stat_set_wins", 32'h1014, 32'h1);
        rd_exp("ctrl_on", 32'h1010, 32'h1);
        check("buserr_timer", 32'(bus_error), 32'h0);
`else
        rd_exp("tcnt_unmap", 32'h1008, 32'h0);
        check("buserr_pre_tcnt", 32'(bus_error), 32'h0);
        step(32'h1008, 32'h5, 1'b1);
        check("buserr_tcnt_wr", 32'(bus_error), 32'h1);
        rd_exp("tcnt_still0", 32'h1008, 32'h0);
`endif
        step(32'h0, 32'h0, 1'b0);
        done = 1'b1;
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL exp_q_drain actual=%0d expected=0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/data_mem_responder.md
DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 Parameter RAM_WORDS, default 256, number of 32-bit RAM words; power of two, 16..1024.
REQ-002 Parameter SW_W, default 16, width of the switch input and the LED output.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 AddressDataMem  input  32  byte address from the processor, valid every cycle.
REQ-006 WriteDataMem  input  32  write data.
REQ-007 WriteEnableMem  input  1  write strobe; commits at the next rising clk edge.
REQ-008 ReadData  output  32  read data; combinational from address and current state.
REQ-009 switches  input  SW_W  asynchronous board switches.
REQ-010 leds  output  SW_W  LED register contents.
REQ-011 bus_error  output  1  sticky illegal-access flag.

Function
REQ-012 Memory map: RAM at 0x0000_0000..(4*RAM_WORDS-4); LED 0x1000 (RW); SWITCH 0x1004 (RO); TIMER_CNT 0x1008 (RW); TIMER_CMP 0x100C (RW); TIMER_CTRL 0x1010 (bit0 enable, RW); STATUS 0x1014 (bit0 match, write-1-to-clear).
REQ-013 Reads are zero-latency: ReadData reflects the addressed location in the same cycle, with no clock edge between address and data.
REQ-014 Writes commit on the rising edge with WriteEnableMem=1, and the new value is readable from the following cycle.
REQ-015 A read-during-write to the same address returns the old value in that cycle.
REQ-016 Unaligned (AddressDataMem[1:0]!=0) or unmapped access: ReadData=0; a write is discarded and sets bus_error on the next edge.
REQ-017 A write to SWITCH is discarded and sets bus_error.
REQ-018 Unused register bits read as 0.
REQ-019 leds drives the low SW_W bits of the LED register.
REQ-020 SWITCH reads the switches through a 2-flop synchronizer, so the read value lags the input by 2 cycles.
REQ-021 TIMER_CNT increments by 1 every cycle while enable=1 and wraps from 0xFFFF_FFFF to 0.
REQ-022 A processor write to TIMER_CNT takes precedence over the increment in that cycle.
REQ-023 STATUS.match sets on the edge after TIMER_CNT==TIMER_CMP while enable=1, then holds until cleared.
REQ-024 A STATUS write-1-to-clear in the same cycle as a new match leaves match=1 (set wins).
REQ-025 bus_error clears only on reset.

Reset
REQ-026 On reset=1 at a clock edge: LED, TIMER_CNT, TIMER_CMP, TIMER_CTRL, STATUS, bus_error and the synchronizer flops all become 0.
REQ-027 RAM contents are not reset.
REQ-028 A write coincident with reset is discarded.
REQ-029 ReadData shows reset values from the cycle after reset.

Configuration
REQ-030 The macro DMEM_TIMER_EN, when defined, compiles in TIMER_CNT, TIMER_CMP, TIMER_CTRL and STATUS.
REQ-031 Without DMEM_TIMER_EN, the timer addresses are unmapped per REQ-016 and no timer logic exists.

Structure
REQ-032 Package dmem_pkg holds the address constants, the register offsets, the STATUS/CTRL bit indices, and a typedef for the decoded region enum (RAM, LED, SW, TCNT, TCMP, TCTRL, STAT, NONE).
REQ-033 One sub-module, mmio_timer, holds the counter, compare, enable and sticky-match logic, instantiated only under DMEM_TIMER_EN.

Verification
REQ-034 Write 0xDEADBEEF to 0x0000_0010, then read 0x10 next cycle -> 0xDEADBEEF; same-cycle read during the write -> prior value.
REQ-035 Write 0x0000_A5A5 to 0x1000 -> leds=0xA5A5 after the edge; set switches=0x1234 -> SWITCH reads 0x1234 from the 2nd cycle on.
REQ-036 Write to 0x0000_0012 or 0x2000 -> ReadData=0, RAM unchanged, bus_error=1 until reset.
REQ-037 TIMER_CNT=0xFFFF_FFFE, CMP=0x0000_0001, enable -> count 0xFFFF_FFFF, 0, 1; STATUS.match=1 on the edge after count=1.
REQ-038 STATUS clear write coincident with a match -> match stays 1; a clear with no match -> 0.
REQ-039 Build without DMEM_TIMER_EN: read 0x1008 -> 0; write 0x1008 -> bus_error=1.
